apb_to_axil_bridge: RTL and testbench
=====================================

// Module: apb_to_axil_bridge
// PURPOSE
//   Single-clock APB slave to AXI4-Lite master bridge for peripheral-side register access.
//   Generalised in address and data width, with programmable PROT.
//   Issues AW and W concurrently, and completes the APB transfer with PREADY only after the AXI response arrives.
//   Adds a response timeout that returns PSLVERR, plus a flush phase that keeps the AXI side protocol-clean after a timeout.
// PARAMETERS
//   ADDR_WIDTH      32      APB/AXI address width
//   DATA_WIDTH      32      APB/AXI data width (32 or 64); strobe width = DATA_WIDTH/8
//   TIMEOUT_CYCLES  256     max cycles from leaving IDLE to AXI response; 0 disables the timeout
//   AXI_PROT        3'b000  constant value driven on AWPROT/ARPROT
// PORTS
//   clk_i        in   1            clock
//   arst_ni      in   1            reset, asynchronous, active-low
//   psel_i       in   1            APB select
//   penable_i    in   1            APB enable (access phase)
//   pwrite_i     in   1            APB direction, 1 = write
//   paddr_i      in   ADDR_WIDTH   APB address
//   pwdata_i     in   DATA_WIDTH   APB write data
//   pstrb_i      in   DATA_WIDTH/8 APB write strobes
//   pready_o     out  1            APB ready
//   prdata_o     out  DATA_WIDTH   APB read data
//   pslverr_o    out  1            APB error
//   axi_prot_o   out  3            AWPROT and ARPROT (= AXI_PROT)
//   aw_addr_o    out  ADDR_WIDTH   AXI write address
//   aw_valid_o   out  1            AW valid
//   aw_ready_i   in   1            AW ready
//   w_data_o     out  DATA_WIDTH   AXI write data
//   w_strb_o     out  DATA_WIDTH/8 AXI write strobes
//   w_valid_o    out  1            W valid
//   w_ready_i    in   1            W ready
//   b_resp_i     in   2            AXI write response
//   b_valid_i    in   1            B valid
//   b_ready_o    out  1            B ready
//   ar_addr_o    out  ADDR_WIDTH   AXI read address
//   ar_valid_o   out  1            AR valid
//   ar_ready_i   in   1            AR ready
//   r_data_i     in   DATA_WIDTH   AXI read data
//   r_resp_i     in   2            AXI read response
//   r_valid_i    in   1            R valid
//   r_ready_o    out  1            R ready
// BEHAVIOUR
//   - Reset: all valid/ready outputs 0, prdata_o 0, pslverr_o 0, state IDLE.
//     Reset is asynchronous and aborts any transfer immediately; axi_prot_o is constant.
//   - FSM: IDLE -> WR or RD on psel_i&penable_i.
//       WR: aw_valid_o and w_valid_o both 1 from the next cycle. Each drops independently after its own handshake.
//           Once both handshakes are done -> WB.
//       WB: b_ready_o = 1; on b_valid_i -> DONE.
//       RD: ar_valid_o = 1; on handshake -> RR.
//       RR: r_ready_o = 1; on r_valid_i -> DONE.
//       DONE: pready_o = 1 for exactly one cycle -> IDLE (or FLUSH if timed out).
//   - Address, wdata and strobes are registered at the IDLE exit and held stable while the corresponding valid is high.
//   - Response latching: on B/R handshake, pslverr_o <= resp[1], so SLVERR and DECERR both map to error.
//     prdata_o <= r_data_i on reads and 0 on writes.
//     prdata_o/pslverr_o hold until the next completion and are cleared at the IDLE exit.
//   - Minimum latency, all readys high and response one cycle after the address: pready_o in the 4th access-phase cycle.
//   - Timeout (TIMEOUT_CYCLES > 0): counter cleared in IDLE, increments in WR/WB/RD/RR.
//       If it reaches TIMEOUT_CYCLES-1 without a response handshake: go to DONE with pslverr_o = 1, prdata_o = 0, marked timed out.
//       A response in the same cycle as the timeout wins, giving normal completion.
//   - FLUSH: holds any not-yet-accepted valid until it is accepted, then holds b_ready_o/r_ready_o until the late response is consumed.
//     That response is discarded; then -> IDLE.
//     APB accesses arriving during FLUSH see pready_o = 0 until IDLE re-entry.
//   - If psel_i drops mid-transfer (an APB violation), the AXI side still completes and DONE still pulses pready_o.
// TESTING
//   - Write 0x1000_0040 <- 0xDEAD_BEEF, pstrb 0xF, all readys 1, OKAY B one cycle later -> AW/W valid in the same cycle, pready_o in the 4th access cycle, pslverr_o 0.
//   - Read 0x2000_0000, ar_ready_i delayed 2 cycles, r_data_i 0x1234_5678 OKAY -> ar_valid_o/ar_addr_o stable throughout, prdata_o 0x1234_5678.
//   - w_ready_i = 1 immediately, aw_ready_i after 3 cycles -> w_valid_o drops after 1 cycle, aw_valid_o held, b_ready_o only after both handshakes.
//   - Read with r_resp_i 2'b11, then write with b_resp_i 2'b10 -> pslverr_o 1 on both. A following OKAY access -> pslverr_o 0.
//   - TIMEOUT_CYCLES = 8, b_valid_i never asserted -> pslverr_o 1 with pready_o; next access is stalled until a late b_valid_i is consumed in FLUSH.
//   - arst_ni low during RR -> all outputs 0 immediately. After release, a new read completes normally.

Source files
------------

// File: rtl/apb_to_axil_bridge.sv
// apb_to_axil_bridge: APB slave to AXI4-Lite master bridge with response timeout and post-timeout flush
module apb_to_axil_bridge #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter logic [2:0]  AXI_PROT       = 3'b000
) (
  input  logic                    clk_i,
  input  logic                    arst_ni,
  input  logic                    psel_i,
  input  logic                    penable_i,
  input  logic                    pwrite_i,
  input  logic [ADDR_WIDTH-1:0]   paddr_i,
  input  logic [DATA_WIDTH-1:0]   pwdata_i,
  input  logic [DATA_WIDTH/8-1:0] pstrb_i,
  output logic                    pready_o,
  output logic [DATA_WIDTH-1:0]   prdata_o,
  output logic                    pslverr_o,
  output logic [2:0]              axi_prot_o,
  output logic [ADDR_WIDTH-1:0]   aw_addr_o,
  output logic                    aw_valid_o,
  input  logic                    aw_ready_i,
  output logic [DATA_WIDTH-1:0]   w_data_o,
  output logic [DATA_WIDTH/8-1:0] w_strb_o,
  output logic                    w_valid_o,
  input  logic                    w_ready_i,
  input  logic [1:0]              b_resp_i,
  input  logic                    b_valid_i,
  output logic                    b_ready_o,
  output logic [ADDR_WIDTH-1:0]   ar_addr_o,
  output logic                    ar_valid_o,
  input  logic                    ar_ready_i,
  input  logic [DATA_WIDTH-1:0]   r_data_i,
  input  logic [1:0]              r_resp_i,
  input  logic                    r_valid_i,
  output logic                    r_ready_o
);
  localparam int unsigned SW   = DATA_WIDTH / 8;
  localparam int unsigned CW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned TMAX = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam logic [CW-1:0] TLIM = TMAX[CW-1:0];

  typedef enum logic [2:0] {S_IDLE, S_WR, S_WB, S_RD, S_RR, S_DONE, S_FLUSH} state_t;

  state_t                r_state;
  logic                  r_wr, r_to;
  logic [CW-1:0]         r_cnt;
  logic                  r_aw_valid, r_w_valid, r_b_ready, r_ar_valid, r_r_ready;
  logic                  r_pready, r_pslverr;
  logic [DATA_WIDTH-1:0] r_prdata, r_wdata;
  logic [SW-1:0]         r_wstrb;
  logic [ADDR_WIDTH-1:0] r_addr;

  logic w_aw_left, w_w_left, w_ar_left, w_req_done, w_resp_hs, w_timeout, w_unused;

  // A valid stays pending only if it is up and not accepted this cycle
  assign w_aw_left  = r_aw_valid & ~aw_ready_i;
  assign w_w_left   = r_w_valid & ~w_ready_i;
  assign w_ar_left  = r_ar_valid & ~ar_ready_i;
  assign w_req_done = r_wr ? ~(w_aw_left | w_w_left) : ~w_ar_left;
  assign w_resp_hs  = (r_b_ready & b_valid_i) | (r_r_ready & r_valid_i);
  assign w_timeout  = (TIMEOUT_CYCLES != 0) && (r_cnt == TLIM);
  assign w_unused   = b_resp_i[0] ^ r_resp_i[0];

  assign pready_o   = r_pready;
  assign prdata_o   = r_prdata;
  assign pslverr_o  = r_pslverr;
  assign axi_prot_o = AXI_PROT;
  assign aw_addr_o  = r_addr;
  assign ar_addr_o  = r_addr;
  assign aw_valid_o = r_aw_valid;
  assign w_data_o   = r_wdata;
  assign w_strb_o   = r_wstrb;
  assign w_valid_o  = r_w_valid;
  assign b_ready_o  = r_b_ready;
  assign ar_valid_o = r_ar_valid;
  assign r_ready_o  = r_r_ready;

  // Transfer FSM: accept APB access, run AXI channels, complete or time out, then flush stragglers
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      r_state    <= S_IDLE;
      r_wr       <= 1'b0;
      r_to       <= 1'b0;
      r_cnt      <= '0;
      r_aw_valid <= 1'b0;
      r_w_valid  <= 1'b0;
      r_b_ready  <= 1'b0;
      r_ar_valid <= 1'b0;
      r_r_ready  <= 1'b0;
      r_pready   <= 1'b0;
      r_pslverr  <= 1'b0;
      r_prdata   <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_addr     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          r_to  <= 1'b0;
          if (psel_i && penable_i) begin
            r_state    <= pwrite_i ? S_WR : S_RD;
            r_wr       <= pwrite_i;
            r_addr     <= paddr_i;
            r_wdata    <= pwdata_i;
            r_wstrb    <= pstrb_i;
            r_aw_valid <= pwrite_i;
            r_w_valid  <= pwrite_i;
            r_ar_valid <= ~pwrite_i;
            r_prdata   <= '0;
            r_pslverr  <= 1'b0;
          end
        end
        S_WR, S_WB, S_RD, S_RR: begin
          r_cnt      <= r_cnt + CW'(1);
          r_aw_valid <= w_aw_left;
          r_w_valid  <= w_w_left;
          r_ar_valid <= w_ar_left;
          if (w_resp_hs) begin
            r_state   <= S_DONE;
            r_b_ready <= 1'b0;
            r_r_ready <= 1'b0;
            r_pready  <= 1'b1;
            r_pslverr <= r_wr ? b_resp_i[1] : r_resp_i[1];
            r_prdata  <= r_wr ? '0 : r_data_i;
          end else if (w_timeout) begin
            r_state   <= S_DONE;
            r_pready  <= 1'b1;
            r_pslverr <= 1'b1;
            r_prdata  <= '0;
            r_to      <= 1'b1;
          end else if ((r_state == S_WR || r_state == S_RD) && w_req_done) begin
            r_state   <= r_wr ? S_WB : S_RR;
            r_b_ready <= r_wr;
            r_r_ready <= ~r_wr;
          end
        end
        S_DONE, S_FLUSH: begin
          r_pready   <= 1'b0;
          r_aw_valid <= w_aw_left;
          r_w_valid  <= w_w_left;
          r_ar_valid <= w_ar_left;
          if (!r_to || w_resp_hs) begin
            r_state   <= S_IDLE;
            r_b_ready <= 1'b0;
            r_r_ready <= 1'b0;
          end else begin
            r_state <= S_FLUSH;
            if (w_req_done) begin
              r_b_ready <= r_wr;
              r_r_ready <= ~r_wr;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_apb_to_axil_bridge.sv
// tb_apb_to_axil_bridge: directed self-checking bench for the APB to AXI4-Lite bridge
module tb_apb_to_axil_bridge;
  logic        clk_i = 1'b0;
  logic        arst_ni = 1'b0;
  logic        psel_i = 1'b0, penable_i = 1'b0, pwrite_i = 1'b0;
  logic [31:0] paddr_i = '0, pwdata_i = '0;
  logic [3:0]  pstrb_i = '0;
  logic        pready_o, pslverr_o;
  logic [31:0] prdata_o;
  logic [2:0]  axi_prot_o;
  logic [31:0] aw_addr_o, w_data_o, ar_addr_o;
  logic [3:0]  w_strb_o;
  logic        aw_valid_o, w_valid_o, b_ready_o, ar_valid_o, r_ready_o;
  logic        aw_ready_i = 1'b1, w_ready_i = 1'b1, ar_ready_i = 1'b1;
  logic        b_valid_i = 1'b0, r_valid_i = 1'b0;
  logic [1:0]  b_resp_i = '0, r_resp_i = '0;
  logic [31:0] r_data_i = '0;
  int          checks = 0;
  int          errors = 0;

  apb_to_axil_bridge #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8), .AXI_PROT(3'b010)
  ) dut (
    .clk_i(clk_i), .arst_ni(arst_ni),
    .psel_i(psel_i), .penable_i(penable_i), .pwrite_i(pwrite_i),
    .paddr_i(paddr_i), .pwdata_i(pwdata_i), .pstrb_i(pstrb_i),
    .pready_o(pready_o), .prdata_o(prdata_o), .pslverr_o(pslverr_o),
    .axi_prot_o(axi_prot_o),
    .aw_addr_o(aw_addr_o), .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i),
    .w_data_o(w_data_o), .w_strb_o(w_strb_o), .w_valid_o(w_valid_o), .w_ready_i(w_ready_i),
    .b_resp_i(b_resp_i), .b_valid_i(b_valid_i), .b_ready_o(b_ready_o),
    .ar_addr_o(ar_addr_o), .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i),
    .r_data_i(r_data_i), .r_resp_i(r_resp_i), .r_valid_i(r_valid_i), .r_ready_o(r_ready_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] d, input logic [1:0] resp, input logic err);
    psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b0; paddr_i = a; ar_ready_i = 1'b1;
    step(); penable_i = 1'b1;
    step();
    chk("rd_arvalid", ar_valid_o, 1); chk("rd_araddr", ar_addr_o, a);
    chk("rd_err_cleared", pslverr_o, 0); chk("rd_data_cleared", prdata_o, 0);
    step();
    chk("rd_rready", r_ready_o, 1); chk("rd_arvalid_drop", ar_valid_o, 0);
    r_valid_i = 1'b1; r_data_i = d; r_resp_i = resp;
    step();
    chk("rd_pready", pready_o, 1); chk("rd_prdata", prdata_o, d); chk("rd_pslverr", pslverr_o, err);
    psel_i = 1'b0; penable_i = 1'b0; r_valid_i = 1'b0;
    step();
    chk("rd_pready_pulse", pready_o, 0); chk("rd_prdata_hold", prdata_o, d);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic [1:0] resp, input logic err);
    psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b1; paddr_i = a; pwdata_i = d; pstrb_i = s;
    aw_ready_i = 1'b1; w_ready_i = 1'b1;
    step(); penable_i = 1'b1;
    step();
    chk("wr_awvalid", aw_valid_o, 1); chk("wr_wvalid", w_valid_o, 1);
    chk("wr_awaddr", aw_addr_o, a); chk("wr_wdata", w_data_o, d); chk("wr_wstrb", w_strb_o, s);
    chk("wr_pready_c2", pready_o, 0); chk("wr_err_cleared", pslverr_o, 0);
    step();
    chk("wr_bready", b_ready_o, 1); chk("wr_pready_c3", pready_o, 0);
    b_valid_i = 1'b1; b_resp_i = resp;
    step();
    chk("wr_pready_c4", pready_o, 1); chk("wr_pslverr", pslverr_o, err); chk("wr_prdata", prdata_o, 0);
    psel_i = 1'b0; penable_i = 1'b0; b_valid_i = 1'b0;
    step();
    chk("wr_pready_pulse", pready_o, 0); chk("wr_bready_drop", b_ready_o, 0);
  endtask

  initial begin
    step(); step();
    chk("rst_pready", pready_o, 0); chk("rst_prdata", prdata_o, 0); chk("rst_pslverr", pslverr_o, 0);
    chk("rst_valids", {aw_valid_o, w_valid_o, ar_valid_o}, 0); chk("rst_readys", {b_ready_o, r_ready_o}, 0);
    chk("rst_prot", axi_prot_o, 3'b010);
    arst_ni = 1'b1;
    step();

    do_write(32'h1000_0040, 32'hDEAD_BEEF, 4'hF, 2'b00, 1'b0);

    psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b0; paddr_i = 32'h2000_0000; ar_ready_i = 1'b0;
    step(); penable_i = 1'b1;
    step(); chk("rdd_arvalid1", ar_valid_o, 1); chk("rdd_addr1", ar_addr_o, 32'h2000_0000);
    step(); chk("rdd_arvalid2", ar_valid_o, 1); chk("rdd_addr2", ar_addr_o, 32'h2000_0000);
    step(); chk("rdd_arvalid3", ar_valid_o, 1); chk("rdd_addr3", ar_addr_o, 32'h2000_0000);
    chk("rdd_rready_early", r_ready_o, 0); ar_ready_i = 1'b1;
    step(); chk("rdd_arvalid_drop", ar_valid_o, 0); chk("rdd_rready", r_ready_o, 1);
    r_valid_i = 1'b1; r_data_i = 32'h1234_5678; r_resp_i = 2'b00; ar_ready_i = 1'b0;
    step(); chk("rdd_pready", pready_o, 1); chk("rdd_prdata", prdata_o, 32'h1234_5678); chk("rdd_err", pslverr_o, 0);
    psel_i = 1'b0; penable_i = 1'b0; r_valid_i = 1'b0; ar_ready_i = 1'b1;
    step(); chk("rdd_pready_pulse", pready_o, 0);

    psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b1; paddr_i = 32'h3000_0008; pwdata_i = 32'hCAFE_F00D;
    pstrb_i = 4'h3; aw_ready_i = 1'b0; w_ready_i = 1'b1;
    step(); penable_i = 1'b1;
    step(); chk("skw_aw1", aw_valid_o, 1); chk("skw_w1", w_valid_o, 1);
    step(); chk("skw_w_drop", w_valid_o, 0); chk("skw_aw2", aw_valid_o, 1); chk("skw_bready_early1", b_ready_o, 0);
    step(); chk("skw_aw3", aw_valid_o, 1); chk("skw_addr", aw_addr_o, 32'h3000_0008); chk("skw_bready_early2", b_ready_o, 0);
    aw_ready_i = 1'b1;
    step(); chk("skw_aw_drop", aw_valid_o, 0); chk("skw_bready", b_ready_o, 1);
    b_valid_i = 1'b1; b_resp_i = 2'b00;
    step(); chk("skw_pready", pready_o, 1); chk("skw_err", pslverr_o, 0);
    psel_i = 1'b0; penable_i = 1'b0; b_valid_i = 1'b0;
    step();

    do_read(32'h0000_0040, 32'hAAAA_5555, 2'b11, 1'b1);
    do_write(32'h0000_0044, 32'h0102_0304, 4'h5, 2'b10, 1'b1);
    do_read(32'h0000_0048, 32'h5A5A_A5A5, 2'b00, 1'b0);
    do_read(32'h0000_004C, 32'h0000_0001, 2'b01, 1'b0);

    psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b1; paddr_i = 32'h5000_0000; pwdata_i = 32'h1111_2222;
    pstrb_i = 4'hF; aw_ready_i = 1'b1; w_ready_i = 1'b1;
    step(); penable_i = 1'b1;
    step();
    repeat (7) step();
    chk("to_not_yet", pready_o, 0); chk("to_bready_wait", b_ready_o, 1);
    step(); chk("to_pready", pready_o, 1); chk("to_pslverr", pslverr_o, 1); chk("to_prdata", prdata_o, 0);
    psel_i = 1'b0; penable_i = 1'b0;
    step(); chk("to_pready_pulse", pready_o, 0); chk("to_flush_bready", b_ready_o, 1);
    psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b0; paddr_i = 32'h6000_0000;
    step(); penable_i = 1'b1;
    step(); chk("fl_stall1", pready_o, 0); chk("fl_no_ar1", ar_valid_o, 0);
    step(); chk("fl_stall2", pready_o, 0); chk("fl_no_ar2", ar_valid_o, 0);
    b_valid_i = 1'b1; b_resp_i = 2'b00;
    step(); chk("fl_bready_drop", b_ready_o, 0); chk("fl_discard", pslverr_o, 1); chk("fl_stall3", pready_o, 0);
    b_valid_i = 1'b0;
    step(); chk("fl_ar_start", ar_valid_o, 1); chk("fl_addr", ar_addr_o, 32'h6000_0000); chk("fl_err_cleared", pslverr_o, 0);
    step(); chk("fl_rready", r_ready_o, 1);
    r_valid_i = 1'b1; r_data_i = 32'h0BAD_F00D; r_resp_i = 2'b00;
    step(); chk("fl_pready", pready_o, 1); chk("fl_prdata", prdata_o, 32'h0BAD_F00D); chk("fl_err", pslverr_o, 0);
    psel_i = 1'b0; penable_i = 1'b0; r_valid_i = 1'b0;
    step();

    psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b0; paddr_i = 32'h7000_0010; ar_ready_i = 1'b1;
    step(); penable_i = 1'b1;
    step();
    step(); chk("ar_rr_reached", r_ready_o, 1);
    arst_ni = 1'b0;
    #1;
    chk("ar_rready", r_ready_o, 0); chk("ar_pready", pready_o, 0); chk("ar_prdata", prdata_o, 0);
    chk("ar_pslverr", pslverr_o, 0); chk("ar_valids", {aw_valid_o, w_valid_o, ar_valid_o, b_ready_o}, 0);
    chk("ar_addr", ar_addr_o, 0);
    psel_i = 1'b0; penable_i = 1'b0;
    step();
    arst_ni = 1'b1;
    step();
    do_read(32'h7000_0020, 32'hFEED_C0DE, 2'b00, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
